// File: rtl/rv_mdu_pkg.sv
// rv_mdu_pkg: shared constants, funct3 encodings and FSM states for the iterative RV32M unit.
package rv_mdu_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, BYP, DONE} state_t;
endpackage

// File: rtl/rv_mdu_div_step.sv
// rv_mdu_div_step: one restoring-division step on an unsigned partial remainder / quotient pair.
module rv_mdu_div_step
  import rv_mdu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W-1:0] rem_n,
  output logic [W-1:0] q_n
);
  logic [W:0] t;
  logic [W:0] diff;
  // rem < d always holds, so t < 2d and the top bit of diff is a pure borrow flag
  always_comb begin
    t = {rem, q[W-1]};
    diff = t - {1'b0, d};
    rem_n = diff[W] ? t[W-1:0] : diff[W-1:0];
    q_n = {q[W-2:0], ~diff[W]};
  end
endmodule

// File: rtl/rv_mdu_iter.sv
// rv_mdu_iter: iterative RV32M multiply/divide unit feeding the register file write port.
// Optional RV_MDU_EARLY_OUT_EN: multiplies with a zero operand finish through the bypass path.
module rv_mdu_iter #(
  parameter int XLEN = rv_mdu_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wr_en
);
  import rv_mdu_pkg::*;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
  state_t state;
  logic [2:0] f3;
  logic neg_q, neg_a, sa, sb, byp, byp_div, byp_mul;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, mc, a_mag, b_mag, d_rem, d_q, nxt_hi, nxt_lo;
  logic [XLEN-1:0] q_s, r_s, a_orig, fix, byp_res;
  logic [XLEN:0] mul_sum;
  logic [2*XLEN-1:0] prod, prod_s;
  rv_mdu_div_step #(.W(XLEN)) u_step (.rem(hi), .q(lo), .d(mc), .rem_n(d_rem), .q_n(d_q));
  always_comb begin
    sa = op_a[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_MULHSU || funct3 == F3_DIV || funct3 == F3_REM);
    sb = op_b[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);
    a_mag = sa ? -op_a : op_a;
    b_mag = sb ? -op_b : op_b;
    byp_div = funct3[2] && (op_b == '0 || ((funct3 == F3_DIV || funct3 == F3_REM) &&
              op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1));
`ifdef RV_MDU_EARLY_OUT_EN
    byp_mul = !funct3[2] && (op_a == '0 || op_b == '0);
`else
    byp_mul = 1'b0;
`endif
    byp = byp_div || byp_mul;
    mul_sum = {1'b0, hi} + {1'b0, lo[0] ? mc : {XLEN{1'b0}}};
    nxt_hi = f3[2] ? d_rem : mul_sum[XLEN:1];
    nxt_lo = f3[2] ? d_q : {mul_sum[0], lo[XLEN-1:1]};
    prod = {nxt_hi, nxt_lo};
    prod_s = neg_q ? -prod : prod;
    q_s = neg_q ? -nxt_lo : nxt_lo;
    r_s = neg_a ? -nxt_hi : nxt_hi;
    fix = f3 == F3_MUL ? prod_s[XLEN-1:0] : !f3[2] ? prod_s[2*XLEN-1:XLEN] : !f3[1] ? q_s : r_s;
    a_orig = neg_a ? -lo : lo;
    // non-zero divisor in bypass can only be the signed-overflow case
    byp_res = !f3[2] ? '0 : mc == '0 ? (f3[1] ? a_orig : '1) : (f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      wr_en <= 1'b0;
      result <= '0;
      rd_out <= '0;
      f3 <= '0;
      neg_q <= 1'b0;
      neg_a <= 1'b0;
      hi <= '0;
      lo <= '0;
      mc <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= byp ? BYP : RUN;
            busy <= 1'b1;
            f3 <= funct3;
            neg_q <= sa ^ sb;
            neg_a <= sa;
            rd_out <= rd_in;
            hi <= '0;
            lo <= funct3[2] ? a_mag : b_mag;
            mc <= funct3[2] ? b_mag : a_mag;
            cnt <= '0;
          end else state <= IDLE;
        RUN: begin
          hi <= nxt_hi;
          lo <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            wr_en <= |rd_out;
            result <= fix;
          end
        end
        BYP: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          wr_en <= |rd_out;
          result <= byp_res;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rv_mdu_iter.sv
// tb_rv_mdu_iter: directed vector table plus multi-cycle sequences for rv_mdu_iter.
module tb_rv_mdu_iter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0] rd_in = '0;
  logic busy, done, wr_en;
  logic [31:0] result;
  logic [4:0] rd_out;
  int pass = 0, total = 0;
`ifdef RV_MDU_EARLY_OUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif
  rv_mdu_iter dut (.clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a),
                   .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done), .result(result),
                   .rd_out(rd_out), .wr_en(wr_en));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] f;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] res;
    int lat;
  } vec_t;
  vec_t v[19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  task automatic run(input bit now, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, output int lat, output logic bsy1);
    if (!now) @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    bsy1 = busy;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, nd, first_k;
    logic b1;
    logic [31:0] seen;
    v[0]  = '{3'b000, 32'hFFFFFFFF, 32'd3, 5'd5, 32'hFFFFFFFD, 33};
    v[1]  = '{3'b011, 32'hFFFFFFFF, 32'd3, 5'd5, 32'h00000002, 33};
    v[2]  = '{3'b001, 32'hFFFFFFFF, 32'd3, 5'd6, 32'hFFFFFFFF, 33};
    v[3]  = '{3'b010, 32'd2, 32'hFFFFFFFF, 5'd7, 32'h00000001, 33};
    v[4]  = '{3'b001, 32'd2, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, 33};
    v[5]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd8, 32'h40000000, 33};
    v[6]  = '{3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 33};
    v[7]  = '{3'b110, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, 33};
    v[8]  = '{3'b101, 32'hFFFFFFF9, 32'd2, 5'd10, 32'h7FFFFFFC, 33};
    v[9]  = '{3'b111, 32'hFFFFFFF9, 32'd2, 5'd10, 32'h00000001, 33};
    v[10] = '{3'b100, 32'd7, 32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 33};
    v[11] = '{3'b110, 32'd7, 32'hFFFFFFFE, 5'd11, 32'h00000001, 33};
    v[12] = '{3'b101, 32'h1234, 32'd0, 5'd12, 32'hFFFFFFFF, 2};
    v[13] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 2};
    v[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 2};
    v[15] = '{3'b111, 32'h1234, 32'd0, 5'd14, 32'h00001234, 2};
    v[16] = '{3'b110, 32'hFFFFFFF9, 32'd0, 5'd14, 32'hFFFFFFF9, 2};
    v[17] = '{3'b000, 32'h12345678, 32'h10, 5'd0, 32'h23456780, 33};
    v[18] = '{3'b000, 32'h12345678, 32'd0, 5'd15, 32'h00000000, ZLAT};
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", {27'd0, rd_out}, 32'd0);
    reset = 1'b0;
    foreach (v[i]) begin
      run(1'b0, v[i].f, v[i].a, v[i].b, v[i].rd, lat, b1);
      chk($sformatf("v%0d_busy1", i), {31'd0, b1}, 32'd1);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_result", i), result, v[i].res);
      chk($sformatf("v%0d_rd", i), {27'd0, rd_out}, {27'd0, v[i].rd});
      chk($sformatf("v%0d_wr_en", i), {31'd0, wr_en}, {31'd0, v[i].rd != 0});
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_held", result, 32'd0);
    // starts while busy must be dropped
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd6; rd_in = 5'd4;
    @(negedge clk);
    op_a = 32'd100; op_b = 32'd100;
    nd = 0; first_k = 0; seen = '0;
    for (int k = 1; k <= 80; k++) begin
      if (done) begin
        nd++;
        if (first_k == 0) first_k = k;
        seen = result;
      end
      start = (k == 5 || k == 20);
      @(negedge clk);
    end
    chk("ign_ndone", nd, 1);
    chk("ign_lat", first_k, 33);
    chk("ign_result", seen, 32'd42);
    // back-to-back issue from the DONE cycle
    run(1'b0, 3'b000, 32'd5, 32'd5, 5'd2, lat, b1);
    chk("b2b_first", result, 32'd25);
    run(1'b1, 3'b101, 32'd100, 32'd7, 5'd3, lat, b1);
    chk("b2b_lat", lat, 33);
    chk("b2b_result", result, 32'd14);
    // async reset in the middle of DIV 100/7
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_no_done", nd, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/rv_mdu_iter.md
Name: rv_mdu_iter

Overview:
Iterative RV32M multiply/divide unit sitting directly downstream of the register file.
- Consumes the two read-port operands (rs1/rs2 values) and the destination index.
- Produces a write-back value, index and write enable that feed the register file write port.
- The datapath stalls on busy while an M-extension instruction is in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, iterations per multiply/divide (must equal XLEN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  32  rs1 value from register file
op_b  in  32  rs2 value from register file
rd_in  in  5  destination register index
busy  out  1  operation in progress; start ignored
done  out  1  one-cycle pulse, result valid
result  out  32  write-back data, held until next accepted start
rd_out  out  5  destination index captured at start
wr_en  out  1  register file write enable, equals done && rd_out!=0

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy, done and wr_en = 0; result and rd_out = 0. The in-flight operation is discarded.
- States:
  - IDLE: start=1 -> latch funct3/op_a/op_b/rd_in. Go to BYP if a bypass case applies, else RUN with counter=0.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter increments; at counter=ITER-1 -> DONE.
  - BYP: result computed combinationally from the latched operands -> DONE.
  - DONE: done=1 for exactly one cycle. Accepts start with the same rules as IDLE (back-to-back issue); otherwise -> IDLE.
- Timing, with the start-sample cycle = cycle 0:
  - Iterative ops: busy=1 cycles 1..32, done=1 in cycle 33 (busy=0).
  - Bypass ops: busy=1 in cycle 1, done in cycle 2.
- start while busy=1: ignored, no queueing.
- Signed handling:
  - Operands are converted to magnitudes per funct3: MULH both signed, MULHSU op_a signed only, DIV/REM both signed.
  - Unsigned core; the sign is fixed in the final cycle.
  - Multiply: 64-bit product. MUL returns bits [31:0], MULH* return [63:32].
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Bypass cases (RISC-V spec values):
  - op_b=0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = op_a.
  - Signed overflow op_a=0x80000000, op_b=0xFFFFFFFF: DIV = 0x80000000; REM = 0.
- rd_out=0: operation runs normally, done pulses, wr_en stays 0 (x0 never written).
- result/rd_out hold their value after done until the next accepted start updates them in DONE/RUN/BYP.

Optional Feature:
RV_MDU_EARLY_OUT_EN
- Defined: MUL/MULH/MULHSU/MULHU with op_a=0 or op_b=0 take the BYP path. result=0, done in cycle 2.
- Undefined: zero operands run the full 32 iterations, done in cycle 33. Results are identical either way.

Decomposition:
- Package rv_mdu_pkg holds:
  - XLEN
  - funct3 encoding constants (F3_MUL..F3_REMU)
  - state encoding (IDLE, RUN, BYP, DONE)
  - counter width constant (5)
- Sub-module rv_mdu_div_step: combinational single restoring-division step (partial remainder, quotient shift), instantiated once. Multiply shift-add stays inline.

Test Plan:
- Reset asserted mid-RUN (cycle 10 of DIV 100/7) -> busy, done, wr_en, result immediately 0; no done pulse afterwards.
- MUL op_a=0xFFFFFFFF(-1), op_b=3, rd_in=5 -> cycle 33: done=1, result=0xFFFFFFFD, rd_out=5, wr_en=1; MULHU same operands -> result=0x00000002.
- DIV op_a=0xFFFFFFF9(-7), op_b=2 -> result=0xFFFFFFFD; REM same -> result=0xFFFFFFFF; both done in cycle 33.
- DIVU op_a=0x1234, op_b=0 -> done in cycle 2, result=0xFFFFFFFF; REM 0x80000000 by 0xFFFFFFFF -> cycle 2, result=0.
- start pulsed in cycles 5 and 20 while busy -> ignored, single done; start asserted in DONE cycle -> accepted, next done 33 cycles later.
- MUL rd_in=0 -> done=1, wr_en=0; with RV_MDU_EARLY_OUT_EN, MUL op_b=0 -> done in cycle 2, result=0.
